cache_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single CPU-side port of `cache_wrapper` between `NUM_REQ` requesters (e.g. instruction fetch, data load/store, debug). It accepts at most one transaction at a time and holds it on the cache port until the cache accepts it. It then waits for the cache response and routes it back to the requester that issued it. A watchdog ends any transaction whose response never arrives.

---
 rtl/cache_port_arbiter_pkg.sv | 17 +
 rtl/cache_port_arbiter_if.sv | 38 +++
 rtl/cache_port_arbiter_rr.sv | 31 +++
 rtl/cache_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_cache_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types and defaults for the cache CPU-port arbiter.
package cache_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2
   } arb_state_e;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

   // Next round-robin start position after idx has been served.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester and cache-side signal bundle of the arbiter.
// master: the arbiter's view; slave: requesters plus cache.
interface cache_port_arbiter_if #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
);
   logic [NUM_REQ-1:0]            req_valid_i;
   logic [NUM_REQ-1:0]            req_ready_o;
   logic [NUM_REQ-1:0]            req_we_i;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_adr_i;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata_i;
   logic [NUM_REQ-1:0]            rsp_valid_o;
   logic [DATA_WIDTH-1:0]         rsp_rdata_o;
   logic                          rsp_err_o;
   logic                          cache_valid_o;
   logic                          cache_ready_i;
   logic                          cache_we_o;
   logic [ADDR_WIDTH-1:0]         cache_adr_o;
   logic [DATA_WIDTH-1:0]         cache_wdata_o;
   logic [DATA_WIDTH-1:0]         cache_rdata_i;
   logic                          cache_resp_valid_i;

   modport master (
      input  req_valid_i, req_we_i, req_adr_i, req_wdata_i,
      input  cache_ready_i, cache_rdata_i, cache_resp_valid_i,
      output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      output cache_valid_o, cache_we_o, cache_adr_o, cache_wdata_o
   );

   modport slave (
      output req_valid_i, req_we_i, req_adr_i, req_wdata_i,
      output cache_ready_i, cache_rdata_i, cache_resp_valid_i,
      input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
      input  cache_valid_o, cache_we_o, cache_adr_o, cache_wdata_o
   );

endinterface

// File: rtl/cache_port_arbiter_rr.sv
// Combinational rotate-priority picker: first set bit of req at or above
// prio, wrapping modulo NUM_REQ. Reusable for other arbiters.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 2,
   localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PW-1:0]      prio,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PW-1:0]      idx
);

   logic found;

   // Scan from prio upward with wraparound; the first requester found wins.
   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         int unsigned j;
         j = (32'(prio) + off) % NUM_REQ;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = PW'(j);
         end
      end
   end

endmodule

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter sharing the cache CPU port between NUM_REQ requesters.
// One transaction in flight; response routed back to the issuing requester;
// a watchdog aborts transactions whose response never arrives.
module cache_port_arbiter
   import cache_arb_pkg::*;
#(
   parameter int unsigned           NUM_REQ    = 2,
   parameter int unsigned           ADDR_WIDTH = 16,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           TIMEOUT    = 255,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA   = DATA_WIDTH'(ERR_DATA_DEFAULT)
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   cache_port_arbiter_if.master bus
);

   localparam int unsigned      PW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   arb_state_e              state_q, state_d;
   logic [PW-1:0]           prio_q, prio_d;
   logic [PW-1:0]           grant_q, grant_d;
   logic                    we_q, we_d;
   logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    cache_valid_q, cache_valid_d;
   logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0]      win_gnt;
   logic [PW-1:0]           win_idx;
   logic [NUM_REQ-1:0]      grant_onehot;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr (
      .req  (bus.req_valid_i),
      .prio (prio_q),
      .gnt  (win_gnt),
      .idx  (win_idx)
   );

   assign grant_onehot = NUM_REQ'(1) << grant_q;

   // Ready only in IDLE, to the round-robin winner; forced low under reset.
   always_comb begin
      bus.req_ready_o = '0;
      if (rst_ni && (state_q == IDLE)) begin
         bus.req_ready_o = win_gnt;
      end
   end

   // Next-state, latch, watchdog and response-demux logic.
   always_comb begin
      state_d       = state_q;
      prio_d        = prio_q;
      grant_d       = grant_q;
      we_d          = we_q;
      adr_d         = adr_q;
      wdata_d       = wdata_q;
      cnt_d         = cnt_q;
      cache_valid_d = 1'b0;
      rsp_valid_d   = '0;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (|bus.req_valid_i) begin
               we_d          = bus.req_we_i[win_idx];
               adr_d         = bus.req_adr_i[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
               wdata_d       = bus.req_wdata_i[32'(win_idx) * DATA_WIDTH +: DATA_WIDTH];
               grant_d       = win_idx;
               prio_d        = PW'(rr_next(32'(win_idx), NUM_REQ));
               cache_valid_d = 1'b1;
               state_d       = ISSUE;
            end
         end

         ISSUE: begin
            cache_valid_d = 1'b1;
            if (bus.cache_ready_i) begin
               cache_valid_d = 1'b0;
               cnt_d         = '0;
               // A response on the accepting edge is delivered without visiting WAIT_RSP.
               if (bus.cache_resp_valid_i) begin
                  rsp_valid_d = grant_onehot;
                  rsp_rdata_d = bus.cache_rdata_i;
                  state_d     = IDLE;
               end else begin
                  state_d = WAIT_RSP;
               end
            end
         end

         WAIT_RSP: begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            if (bus.cache_resp_valid_i) begin
               rsp_valid_d = grant_onehot;
               rsp_rdata_d = bus.cache_rdata_i;
               state_d     = IDLE;
            end else if (cnt_q >= CNT_LAST) begin
               rsp_valid_d = grant_onehot;
               rsp_rdata_d = ERR_DATA;
               rsp_err_d   = 1'b1;
               state_d     = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transaction in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         prio_q        <= '0;
         grant_q       <= '0;
         we_q          <= 1'b0;
         adr_q         <= '0;
         wdata_q       <= '0;
         cnt_q         <= '0;
         cache_valid_q <= 1'b0;
         rsp_valid_q   <= '0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         prio_q        <= prio_d;
         grant_q       <= grant_d;
         we_q          <= we_d;
         adr_q         <= adr_d;
         wdata_q       <= wdata_d;
         cnt_q         <= cnt_d;
         cache_valid_q <= cache_valid_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
      end
   end

   assign bus.cache_valid_o = cache_valid_q;
   assign bus.cache_we_o    = we_q;
   assign bus.cache_adr_o   = adr_q;
   assign bus.cache_wdata_o = wdata_q;
   assign bus.rsp_valid_o   = rsp_valid_q;
   assign bus.rsp_rdata_o   = rsp_rdata_q;
   assign bus.rsp_err_o     = rsp_err_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Bench for cache_port_arbiter: per-port request queues, a stub cache with
// programmable delays, and a scoreboard fed at request acceptance.
module tb_cache_port_arbiter;

   localparam int unsigned N   = 2;
   localparam int unsigned AW  = 16;
   localparam int unsigned DW  = 32;
   localparam int unsigned TMO = 8;

   typedef struct {
      int            port;
      logic          we;
      logic [AW-1:0] adr;
      logic [DW-1:0] wdata;
      int            rdy_dly;
      int            rsp_dly;
      logic          chk_data;
      logic [DW-1:0] exp_rdata;
      logic          exp_err;
   } vec_t;

   logic clk_i  = 1'b0;
   logic rst_ni = 1'b0;
   always #5 clk_i = ~clk_i;

   cache_port_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   cache_port_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (TMO)
   ) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .bus    (bus)
   );

   int   checks   = 0;
   int   failures = 0;
   vec_t pend [N][$];
   vec_t sb[$];
   vec_t cq[$];
   int   grant_log[$];
   bit   accepted [N];
   int   stub_rdy   = 1;
   int   stub_rsp   = 2;
   bit   stub_never = 1'b0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input int port, input logic we, input logic [AW-1:0] adr,
                               input logic [DW-1:0] wd, input int rdy, input int rsp,
                               input logic chk, input logic [DW-1:0] exp, input logic err);
      vec_t v;
      v.port = port; v.we = we; v.adr = adr; v.wdata = wd;
      v.rdy_dly = rdy; v.rsp_dly = rsp;
      v.chk_data = chk; v.exp_rdata = exp; v.exp_err = err;
      return v;
   endfunction

   function automatic int busy();
      int s;
      s = sb.size();
      for (int i = 0; i < N; i++) s += pend[i].size();
      return s;
   endfunction

   function automatic logic [127:0] all_outs();
      return 128'({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o,
                   bus.cache_valid_o, bus.cache_we_o, bus.cache_adr_o, bus.cache_wdata_o});
   endfunction

   task automatic wait_done(input string name, input int budget);
      int c;
      c = 0;
      while (busy() != 0 && c < budget) begin
         @(negedge clk_i);
         c++;
      end
      check(name, 128'(busy()), 128'(0));
      repeat (2) @(negedge clk_i);
   endtask

   // Requester driver: presents the head of each port queue, pops on acceptance.
   initial begin
      bus.req_valid_i = '0;
      bus.req_we_i    = '0;
      bus.req_adr_i   = '0;
      bus.req_wdata_i = '0;
      forever begin
         @(posedge clk_i);
         #1;
         for (int i = 0; i < N; i++) begin
            if (accepted[i]) begin
               accepted[i] = 1'b0;
               if (pend[i].size() > 0) void'(pend[i].pop_front());
            end
            if (pend[i].size() > 0) begin
               bus.req_valid_i[i]          = 1'b1;
               bus.req_we_i[i]             = pend[i][0].we;
               bus.req_adr_i[i*AW +: AW]   = pend[i][0].adr;
               bus.req_wdata_i[i*DW +: DW] = pend[i][0].wdata;
            end else begin
               bus.req_valid_i[i] = 1'b0;
            end
         end
      end
   end

   // Stub cache: ready after stub_rdy cycles of valid, response stub_rsp cycles later,
   // read data = {16'hBEEF, address}.
   initial begin
      int st, cnt, cnt2;
      logic [AW-1:0] padr;
      st = 0; cnt = 0; cnt2 = 0; padr = '0;
      bus.cache_ready_i      = 1'b0;
      bus.cache_resp_valid_i = 1'b0;
      bus.cache_rdata_i      = '0;
      forever begin
         @(posedge clk_i);
         #1;
         bus.cache_ready_i      = 1'b0;
         bus.cache_resp_valid_i = 1'b0;
         if (!rst_ni) begin
            st = 0;
         end else begin
            if (st != 1 && bus.cache_valid_o) begin
               st  = 1;
               cnt = 0;
            end
            if (st == 1) begin
               if (cnt >= stub_rdy) begin
                  bus.cache_ready_i = 1'b1;
                  padr = bus.cache_adr_o;
                  cnt2 = 0;
                  if (!stub_never && stub_rsp == 0) begin
                     bus.cache_resp_valid_i = 1'b1;
                     bus.cache_rdata_i      = {16'hBEEF, padr};
                     st = 0;
                  end else begin
                     st = 2;
                  end
               end else begin
                  cnt++;
               end
            end else if (st == 2) begin
               cnt2++;
               if (!stub_never && cnt2 >= stub_rsp) begin
                  bus.cache_resp_valid_i = 1'b1;
                  bus.cache_rdata_i      = {16'hBEEF, padr};
                  st = 0;
               end
            end
         end
      end
   end

   // Monitor/scoreboard: acceptance pushes expectations, cache handshake and
   // response pulses pop and compare.
   always @(negedge clk_i) begin
      vec_t v;
      if (rst_ni) begin
         for (int i = 0; i < N; i++) begin
            if (bus.req_valid_i[i] && bus.req_ready_o[i] && pend[i].size() > 0) begin
               v = pend[i][0];
               v.port = i;
               sb.push_back(v);
               cq.push_back(v);
               grant_log.push_back(i);
               accepted[i] = 1'b1;
            end
         end
         if (bus.cache_valid_o && bus.cache_ready_i) begin
            if (cq.size() == 0) begin
               checks++; failures++;
               $display("FAIL cache_issue: got unexpected cache handshake adr=%0h required none", bus.cache_adr_o);
            end else begin
               v = cq.pop_front();
               check("cache_adr", 128'(bus.cache_adr_o), 128'(v.adr));
               check("cache_we", 128'(bus.cache_we_o), 128'(v.we));
               check("cache_wdata", 128'(bus.cache_wdata_o), 128'(v.wdata));
            end
         end
         if (bus.rsp_valid_o != '0) begin
            if (sb.size() == 0) begin
               checks++; failures++;
               $display("FAIL unexpected_rsp: got rsp_valid=%0b required 0", bus.rsp_valid_o);
            end else begin
               v = sb.pop_front();
               check("rsp_port", 128'(bus.rsp_valid_o), 128'(N'(1) << v.port));
               check("rsp_err", 128'(bus.rsp_err_o), 128'(v.exp_err));
               if (v.chk_data) check("rsp_rdata", 128'(bus.rsp_rdata_o), 128'(v.exp_rdata));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "global timeout");
   end

   initial begin
      vec_t tbl[6];
      int c;
      int n;
      logic [15:0] order;

      tbl[0] = mk(0, 1'b1, 16'h0010, 32'hABCD1234, 1, 2, 1'b0, 32'h0,        1'b0);
      tbl[1] = mk(0, 1'b0, 16'h0010, 32'h0,        1, 2, 1'b1, 32'hBEEF0010, 1'b0);
      tbl[2] = mk(1, 1'b0, 16'h1234, 32'h0,        0, 0, 1'b1, 32'hBEEF1234, 1'b0);
      tbl[3] = mk(0, 1'b0, 16'hFFFF, 32'h0,        3, 1, 1'b1, 32'hBEEFFFFF, 1'b0);
      tbl[4] = mk(1, 1'b1, 16'h0000, 32'h5555AAAA, 0, 4, 1'b0, 32'h0,        1'b0);
      tbl[5] = mk(1, 1'b0, 16'h8001, 32'h0,        2, 0, 1'b1, 32'hBEEF8001, 1'b0);

      // reset state
      repeat (3) @(negedge clk_i);
      check("reset_outputs", all_outs(), 128'(0));
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      check("idle_outputs", all_outs(), 128'(0));

      // table-driven single transactions
      for (int k = 0; k < 6; k++) begin
         stub_rdy = tbl[k].rdy_dly;
         stub_rsp = tbl[k].rsp_dly;
         pend[tbl[k].port].push_back(tbl[k]);
         wait_done($sformatf("vec%0d_done", k), 60);
      end

      // best-case latency and single-cycle pulse
      stub_rdy = 0; stub_rsp = 0;
      pend[1].push_back(mk(1, 1'b0, 16'h0042, 32'h0, 0, 0, 1'b1, 32'hBEEF0042, 1'b0));
      c = 0;
      while (!bus.req_ready_o[1] && c < 20) begin @(negedge clk_i); c++; end
      check("lat_accept_seen", 128'(c < 20), 128'(1));
      @(negedge clk_i);
      check("lat_issue_quiet", 128'(bus.rsp_valid_o), 128'(0));
      @(negedge clk_i);
      check("lat_pulse", 128'(bus.rsp_valid_o), 128'(2'b10));
      check("lat_rdata", 128'(bus.rsp_rdata_o), 128'(32'hBEEF0042));
      @(negedge clk_i);
      check("lat_single_pulse", 128'(bus.rsp_valid_o), 128'(0));
      check("lat_rdata_hold", 128'(bus.rsp_rdata_o), 128'(32'hBEEF0042));
      wait_done("lat_done", 20);

      // simultaneous requests: round-robin order 0,1,0,1
      stub_rdy = 1; stub_rsp = 1;
      grant_log.delete();
      pend[0].push_back(mk(0, 1'b0, 16'h0100, 32'h0, 1, 1, 1'b1, 32'hBEEF0100, 1'b0));
      pend[0].push_back(mk(0, 1'b0, 16'h0101, 32'h0, 1, 1, 1'b1, 32'hBEEF0101, 1'b0));
      pend[1].push_back(mk(1, 1'b0, 16'h0200, 32'h0, 1, 1, 1'b1, 32'hBEEF0200, 1'b0));
      pend[1].push_back(mk(1, 1'b1, 16'h0201, 32'h12345678, 1, 1, 1'b0, 32'h0, 1'b0));
      wait_done("rr_done", 120);
      check("rr_grant_count", 128'(grant_log.size()), 128'(4));
      order = '0;
      for (int j = 0; j < 4 && j < grant_log.size(); j++) order[j*4 +: 4] = 4'(grant_log[j]);
      check("rr_grant_order", 128'(order), 128'(16'h1010));

      // cache stalls 5 cycles: request held stable, no further acceptance
      stub_rdy = 5; stub_rsp = 1;
      pend[0].push_back(mk(0, 1'b0, 16'h0A0A, 32'h0, 5, 1, 1'b1, 32'hBEEF0A0A, 1'b0));
      pend[1].push_back(mk(1, 1'b0, 16'h0B0B, 32'h0, 5, 1, 1'b1, 32'hBEEF0B0B, 1'b0));
      c = 0;
      while (!bus.cache_valid_o && c < 20) begin @(negedge clk_i); c++; end
      check("stall_issue_seen", 128'(c < 20), 128'(1));
      for (int s = 0; s < 5; s++) begin
         check("stall_valid", 128'(bus.cache_valid_o), 128'(1));
         check("stall_adr", 128'(bus.cache_adr_o), 128'(16'h0A0A));
         check("stall_no_ready", 128'(bus.req_ready_o), 128'(0));
         @(negedge clk_i);
      end
      wait_done("stall_done", 100);

      // watchdog: stub never responds
      stub_rdy = 0; stub_never = 1'b1;
      pend[1].push_back(mk(1, 1'b0, 16'h0077, 32'h0, 0, 0, 1'b1, 32'hDEADBEEF, 1'b1));
      c = 0;
      while (!(bus.cache_valid_o && bus.cache_ready_i) && c < 20) begin @(negedge clk_i); c++; end
      check("tmo_handshake_seen", 128'(c < 20), 128'(1));
      n = 0;
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk_i);
         if (bus.rsp_valid_o != '0) n++;
      end
      check("tmo_quiet_cycles", 128'(n), 128'(0));
      @(negedge clk_i);
      check("tmo_pulse", 128'(bus.rsp_valid_o), 128'(2'b10));
      check("tmo_err", 128'(bus.rsp_err_o), 128'(1));
      check("tmo_rdata", 128'(bus.rsp_rdata_o), 128'(32'hDEADBEEF));
      @(negedge clk_i);
      check("tmo_pulse_end", 128'({bus.rsp_valid_o, bus.rsp_err_o}), 128'(0));
      stub_never = 1'b0;
      wait_done("tmo_done", 40);

      // reset during WAIT_RSP
      stub_rdy = 0; stub_rsp = 6;
      pend[0].push_back(mk(0, 1'b0, 16'h0300, 32'h0, 0, 6, 1'b1, 32'hBEEF0300, 1'b0));
      c = 0;
      while (!(bus.cache_valid_o && bus.cache_ready_i) && c < 20) begin @(negedge clk_i); c++; end
      check("rst_handshake_seen", 128'(c < 20), 128'(1));
      @(posedge clk_i);
      @(posedge clk_i);
      #2 rst_ni = 1'b0;
      for (int i = 0; i < N; i++) begin pend[i].delete(); accepted[i] = 1'b0; end
      sb.delete();
      cq.delete();
      #1 check("rst_async_outputs", all_outs(), 128'(0));
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk_i);
         if (bus.rsp_valid_o != '0) n++;
      end
      check("rst_no_rsp", 128'(n), 128'(0));
      stub_rsp = 1; stub_rdy = 1;
      grant_log.delete();
      pend[0].push_back(mk(0, 1'b0, 16'h0400, 32'h0, 1, 1, 1'b1, 32'hBEEF0400, 1'b0));
      pend[1].push_back(mk(1, 1'b0, 16'h0500, 32'h0, 1, 1, 1'b1, 32'hBEEF0500, 1'b0));
      wait_done("rst_after_done", 60);
      check("rst_first_grant", 128'(grant_log.size() > 0 ? grant_log[0] : 99), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
